// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with hazard stall and flush bubbles.
// Define CTRL_PIPE_FWD_EN for the forwarding build (load-use stall only, fwd_a/fwd_b active).
module ctrl_pipe #(
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 2
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               enable,
   input  logic               flush,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic               id_reg_dst,
   input  logic               id_branch,
   input  logic               id_mem_read,
   input  logic               id_mem_2_reg,
   input  logic               id_mem_write,
   input  logic               id_alu_src,
   input  logic               id_reg_write,
   input  logic               id_jump,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic [REG_AW-1:0]  id_rd,
   output logic               stall,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_reg_dst,
   output logic               ex_alu_src,
   output logic [REG_AW-1:0]  ex_rs,
   output logic [REG_AW-1:0]  ex_rt,
   output logic               mem_branch,
   output logic               mem_jump,
   output logic               mem_read,
   output logic               mem_write,
   output logic               wb_mem_2_reg,
   output logic               wb_reg_write,
   output logic [REG_AW-1:0]  wb_dest,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b
);

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               reg_dst;
      logic               branch;
      logic               mem_read;
      logic               mem_2_reg;
      logic               mem_write;
      logic               alu_src;
      logic               reg_write;
      logic               jump;
      logic [REG_AW-1:0]  rs;
      logic [REG_AW-1:0]  rt;
      logic [REG_AW-1:0]  dest;
   } ex_t;

   typedef struct packed {
      logic              branch;
      logic              jump;
      logic              mem_read;
      logic              mem_write;
      logic              mem_2_reg;
      logic              reg_write;
      logic [REG_AW-1:0] dest;
   } mem_t;

   typedef struct packed {
      logic              mem_2_reg;
      logic              reg_write;
      logic [REG_AW-1:0] dest;
   } wb_t;

   ex_t  ex_q, ex_d, id_word;
   mem_t mem_q, mem_d;
   wb_t  wb_q, wb_d;
   logic uses_rt;

   // $0 is hard-wired zero, so a writer targeting it never creates a dependency.
   function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                                input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                input logic use_rt);
      return wr && (dst != '0) && ((dst == rs) || (use_rt && (dst == rt)));
   endfunction

   assign uses_rt = ~id_alu_src | id_mem_write | id_branch;

   always_comb begin
      id_word           = '0;
      id_word.alu_op    = id_alu_op;
      id_word.reg_dst   = id_reg_dst;
      id_word.branch    = id_branch;
      id_word.mem_read  = id_mem_read;
      id_word.mem_2_reg = id_mem_2_reg;
      id_word.mem_write = id_mem_write;
      id_word.alu_src   = id_alu_src;
      id_word.reg_write = id_reg_write;
      id_word.jump      = id_jump;
      id_word.rs        = id_rs;
      id_word.rt        = id_rt;
      id_word.dest      = id_reg_dst ? id_rd : id_rt;
   end

`ifdef CTRL_PIPE_FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (mem_q.reg_write && (mem_q.dest != '0) && (mem_q.dest == src))
         return 2'b10;
      else if (wb_q.reg_write && (wb_q.dest != '0) && (wb_q.dest == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign stall = ex_q.mem_read & hit(ex_q.reg_write, ex_q.dest, id_rs, id_rt, uses_rt);
   assign fwd_a = fwd_sel(ex_q.rs);
   assign fwd_b = fwd_sel(ex_q.rt);
`else
   assign stall = hit(ex_q.reg_write, ex_q.dest, id_rs, id_rt, uses_rt)
                | hit(mem_q.reg_write, mem_q.dest, id_rs, id_rt, uses_rt);
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (enable) begin
         wb_d.mem_2_reg = mem_q.mem_2_reg;
         wb_d.reg_write = mem_q.reg_write;
         wb_d.dest      = mem_q.dest;
         if (flush) begin
            mem_d = '0;
         end else begin
            mem_d.branch    = ex_q.branch;
            mem_d.jump      = ex_q.jump;
            mem_d.mem_read  = ex_q.mem_read;
            mem_d.mem_write = ex_q.mem_write;
            mem_d.mem_2_reg = ex_q.mem_2_reg;
            mem_d.reg_write = ex_q.reg_write;
            mem_d.dest      = ex_q.dest;
         end
         // Flush outranks stall; both leave a bubble in EX.
         ex_d = (flush || stall) ? '0 : id_word;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign ex_alu_op    = ex_q.alu_op;
   assign ex_reg_dst   = ex_q.reg_dst;
   assign ex_alu_src   = ex_q.alu_src;
   assign ex_rs        = ex_q.rs;
   assign ex_rt        = ex_q.rt;
   assign mem_branch   = mem_q.branch;
   assign mem_jump     = mem_q.jump;
   assign mem_read     = mem_q.mem_read;
   assign mem_write    = mem_q.mem_write;
   assign wb_mem_2_reg = wb_q.mem_2_reg;
   assign wb_reg_write = wb_q.reg_write;
   assign wb_dest      = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized bench for ctrl_pipe against an instruction-record pipeline model.
module tb_ctrl_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       arst, enable, flush;
   logic [1:0] id_alu_op;
   logic       id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write;
   logic       id_alu_src, id_reg_write, id_jump;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       stall;
   logic [1:0] ex_alu_op;
   logic       ex_reg_dst, ex_alu_src;
   logic [4:0] ex_rs, ex_rt;
   logic       mem_branch, mem_jump, mem_read, mem_write;
   logic       wb_mem_2_reg, wb_reg_write;
   logic [4:0] wb_dest;
   logic [1:0] fwd_a, fwd_b;

   ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
      .clk(clk), .arst(arst), .enable(enable), .flush(flush),
      .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
      .id_mem_read(id_mem_read), .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_jump(id_jump),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .stall(stall), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_jump(mem_jump),
      .mem_read(mem_read), .mem_write(mem_write), .wb_mem_2_reg(wb_mem_2_reg),
      .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // Each stage holds a whole instruction record; outputs pick the fields that stage exposes.
   typedef struct {
      logic [1:0] alu_op;
      logic       reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump;
      logic [4:0] rs, rt, dest;
   } instr_t;

   instr_t m_ex, m_mem, m_wb, nop_i;
   int n_checks = 0;
   int n_fail   = 0;

   function automatic instr_t id_word();
      instr_t w;
      w.alu_op = id_alu_op;      w.reg_dst = id_reg_dst;     w.branch = id_branch;
      w.mem_read = id_mem_read;  w.mem_2_reg = id_mem_2_reg; w.mem_write = id_mem_write;
      w.alu_src = id_alu_src;    w.reg_write = id_reg_write; w.jump = id_jump;
      w.rs = id_rs;              w.rt = id_rt;
      w.dest = id_reg_dst ? id_rd : id_rt;
      return w;
   endfunction

   function automatic bit depends(instr_t producer, instr_t consumer);
      bit reads_rt;
      reads_rt = !consumer.alu_src || consumer.mem_write || consumer.branch;
      if (!producer.reg_write || producer.dest == 0) return 0;
      return (producer.dest == consumer.rs) || (reads_rt && producer.dest == consumer.rt);
   endfunction

   function automatic bit exp_stall();
`ifdef CTRL_PIPE_FWD_EN
      return m_ex.mem_read && depends(m_ex, id_word());
`else
      return depends(m_ex, id_word()) || depends(m_mem, id_word());
`endif
   endfunction

`ifdef CTRL_PIPE_FWD_EN
   function automatic logic [1:0] exp_fwd(logic [4:0] r);
      if (m_mem.reg_write && m_mem.dest != 0 && m_mem.dest == r) return 2'b10;
      if (m_wb.reg_write && m_wb.dest != 0 && m_wb.dest == r) return 2'b01;
      return 2'b00;
   endfunction
`endif

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("stall", 32'(stall), 32'(exp_stall()));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex.alu_op));
      chk("ex_reg_dst", 32'(ex_reg_dst), 32'(m_ex.reg_dst));
      chk("ex_alu_src", 32'(ex_alu_src), 32'(m_ex.alu_src));
      chk("ex_rs", 32'(ex_rs), 32'(m_ex.rs));
      chk("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
      chk("mem_branch", 32'(mem_branch), 32'(m_mem.branch));
      chk("mem_jump", 32'(mem_jump), 32'(m_mem.jump));
      chk("mem_read", 32'(mem_read), 32'(m_mem.mem_read));
      chk("mem_write", 32'(mem_write), 32'(m_mem.mem_write));
      chk("wb_mem_2_reg", 32'(wb_mem_2_reg), 32'(m_wb.mem_2_reg));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(m_wb.reg_write));
      chk("wb_dest", 32'(wb_dest), 32'(m_wb.dest));
`ifdef CTRL_PIPE_FWD_EN
      chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(m_ex.rs)));
      chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(m_ex.rt)));
`else
      chk("fwd_a", 32'(fwd_a), 32'd0);
      chk("fwd_b", 32'(fwd_b), 32'd0);
`endif
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      instr_t n_ex, n_mem, n_wb;
      #1;
      if (arst) begin
         m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
      end
      check_all();
      n_ex = m_ex; n_mem = m_mem; n_wb = m_wb;
      if (!arst && enable) begin
         n_wb  = m_mem;
         n_mem = flush ? nop_i : m_ex;
         n_ex  = (flush || exp_stall()) ? nop_i : id_word();
      end
      @(posedge clk);
      if (arst) begin
         m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
      end else begin
         m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
      end
      @(negedge clk);
   endtask

   task automatic set_id(logic [1:0] op, logic rdst, logic br, logic mrd, logic m2r, logic mwr,
                         logic asrc, logic rwr, logic jmp, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      id_alu_op = op;   id_reg_dst = rdst;  id_branch = br;   id_mem_read = mrd;
      id_mem_2_reg = m2r; id_mem_write = mwr; id_alu_src = asrc; id_reg_write = rwr;
      id_jump = jmp;    id_rs = rs;         id_rt = rt;       id_rd = rd;
   endtask

   task automatic nop();                          set_id(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0); endtask
   task automatic rtype(logic [4:0] rs, rt, rd);   set_id(2'd2, 1, 0, 0, 0, 0, 0, 1, 0, rs, rt, rd);       endtask
   task automatic lw(logic [4:0] rs, rt);          set_id(2'd0, 0, 0, 1, 1, 0, 1, 1, 0, rs, rt, 5'd0);     endtask
   task automatic addi(logic [4:0] rs, rt);        set_id(2'd0, 0, 0, 0, 0, 0, 1, 1, 0, rs, rt, 5'd0);     endtask

   initial begin
      nop_i = '{default: '0};
      m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
      arst = 1'b1; enable = 1'b1; flush = 1'b0;
      nop();
      @(negedge clk);
      tick(); tick();
      chk("lit_reset_ex_alu_op", 32'(ex_alu_op), 32'd0);
      chk("lit_reset_wb_dest", 32'(wb_dest), 32'd0);
      chk("lit_reset_stall", 32'(stall), 32'd0);

      // R-type add $3 propagation
      arst = 1'b0;
      rtype(5'd1, 5'd2, 5'd3); tick();
      nop();
      chk("lit_prop_ex_reg_dst", 32'(ex_reg_dst), 32'd1);
      chk("lit_prop_ex_alu_op", 32'(ex_alu_op), 32'd2);
      tick(); tick();
      chk("lit_prop_wb_reg_write", 32'(wb_reg_write), 32'd1);
      chk("lit_prop_wb_dest", 32'(wb_dest), 32'd3);

      // Asynchronous reset with a load in flight
      lw(5'd1, 5'd5); tick();
      rtype(5'd5, 5'd6, 5'd8);
      arst = 1'b1; #1;
      chk("lit_arst_ex_alu_src", 32'(ex_alu_src), 32'd0);
      chk("lit_arst_ex_rt", 32'(ex_rt), 32'd0);
      chk("lit_arst_stall", 32'(stall), 32'd0);
      tick();
      arst = 1'b0; nop(); tick();

`ifdef CTRL_PIPE_FWD_EN
      rtype(5'd1, 5'd2, 5'd4); tick();
      rtype(5'd4, 5'd4, 5'd6); #1;
      chk("lit_fwd_nostall", 32'(stall), 32'd0);
      tick();
      chk("lit_fwd_a_mem", 32'(fwd_a), 32'd2);
      chk("lit_fwd_b_mem", 32'(fwd_b), 32'd2);
      rtype(5'd1, 5'd2, 5'd0); tick();
      rtype(5'd0, 5'd0, 5'd7); tick();
      chk("lit_fwd_zero_a", 32'(fwd_a), 32'd0);
      chk("lit_fwd_zero_b", 32'(fwd_b), 32'd0);
      lw(5'd1, 5'd5); tick();
      rtype(5'd5, 5'd2, 5'd9); #1;
      chk("lit_loaduse_stall", 32'(stall), 32'd1);
      tick();
      chk("lit_loaduse_release", 32'(stall), 32'd0);
      tick();
      chk("lit_loaduse_fwd_a_wb", 32'(fwd_a), 32'd1);
`else
      rtype(5'd1, 5'd2, 5'd4); tick();
      rtype(5'd4, 5'd4, 5'd6); #1;
      chk("lit_nofwd_stall_ex", 32'(stall), 32'd1);
      tick();
      chk("lit_nofwd_stall_mem", 32'(stall), 32'd1);
      tick();
      chk("lit_nofwd_stall_clear", 32'(stall), 32'd0);
      tick();
`endif

      // addi $7 followed by an rt=7 immediate op: rt is not read
      nop(); tick(); tick();
      addi(5'd1, 5'd7); tick();
      addi(5'd1, 5'd7); #1;
      chk("lit_addi_nostall", 32'(stall), 32'd0);
      tick();

      // Flush coinciding with a load-use stall
      lw(5'd2, 5'd5); tick();
      rtype(5'd5, 5'd3, 5'd9); #1;
      chk("lit_flush_stall_in", 32'(stall), 32'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("lit_flush_ex_alu_op", 32'(ex_alu_op), 32'd0);
      chk("lit_flush_ex_rs", 32'(ex_rs), 32'd0);
      chk("lit_flush_mem_read", 32'(mem_read), 32'd0);
      chk("lit_flush_wb_dest", 32'(wb_dest), 32'd7);
      chk("lit_flush_wb_reg_write", 32'(wb_reg_write), 32'd1);

      // Freeze for three cycles
      rtype(5'd1, 5'd2, 5'd3); tick();
      enable = 1'b0;
      rtype(5'd2, 5'd3, 5'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lit_hold_ex_alu_op", 32'(ex_alu_op), 32'd2);
         chk("lit_hold_ex_rs", 32'(ex_rs), 32'd1);
      end
      enable = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         set_id(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         flush  = ($urandom_range(0, 9) == 0);
         enable = ($urandom_range(0, 7) != 0);
         arst   = ($urandom_range(0, 99) == 0);
         tick();
      end
      arst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
